// File: rtl/fc_layer_seq.sv
// fc_layer_seq: fully-connected layer with a single sequential MAC.
// A frame of IN_LEN beats, each carrying IN_CH signed features, is buffered.
// Then, for each output neuron o, the bias and then every weight are streamed
// from external 1-cycle synchronous ROMs and accumulated. The result is
// optionally ReLU'd, requantised to int8, and handed out over ready/valid.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   in_*         input beat handshake and packed channel data
//   w_addr_o/w_data_i  weight ROM (address o*N_IN+i, data one cycle later)
//   b_addr_o/b_data_i  bias ROM (address o, data one cycle later)
//   out_*        result handshake, int8 sign-extended to 32 bits, last flag
//   busy_o       high whenever a frame is being processed
module fc_layer_seq #(
  parameter int unsigned IN_CH   = 16,
  parameter int unsigned IN_LEN  = 16,
  parameter int unsigned OUT_DIM = 32,
  parameter int unsigned IN_W    = 32,
  parameter int unsigned ACC_W   = 48,
  parameter int          Q_MULT  = 1,
  parameter int unsigned Q_SHIFT = 16,
  parameter bit          RELU    = 1'b1,
  parameter int unsigned WA_W    = 13,
  parameter int unsigned BA_W    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [IN_CH*IN_W-1:0]  in_data_i,
  output logic [WA_W-1:0]        w_addr_o,
  input  logic signed [7:0]      w_data_i,
  output logic [BA_W-1:0]        b_addr_o,
  input  logic signed [31:0]     b_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            out_data_o,
  output logic                   out_last_o,
  output logic                   busy_o
);

  localparam int unsigned NIn = IN_CH * IN_LEN;
  localparam int unsigned KW  = $clog2(NIn + 1);
  localparam int unsigned IW  = (NIn > 1) ? $clog2(NIn) : 1;
  localparam int unsigned SW  = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int unsigned OW  = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int unsigned PW  = ACC_W + 32;
  localparam logic signed [31:0]   QMul = Q_MULT;
  localparam logic signed [PW-1:0] Rnd  =
      (Q_SHIFT == 0) ? '0 : (PW'(1) << ((Q_SHIFT == 0) ? 0 : Q_SHIFT - 1));

  if ((ACC_W < IN_W + 8 + $clog2(NIn)) || (ACC_W < 33) || (WA_W < $clog2(OUT_DIM * NIn)) ||
      (BA_W < OW) || (Q_SHIFT >= PW)) begin : g_param_check
    $error("fc_layer_seq: illegal parameter combination");
  end

  typedef enum logic [2:0] {StLoad, StBias, StMac, StQuant, StOut} state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          beat_q;
  logic [OW-1:0]          o_q;
  logic [KW-1:0]          k_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [WA_W-1:0]        w_addr_q;
  logic [31:0]            out_data_q;
  logic                   out_valid_q, out_last_q;
  logic [IN_W-1:0]        feat_q [NIn];

  logic                   last_beat, last_out;
  logic [IW-1:0]          feat_idx;
  logic signed [IN_W-1:0] feat_sel;
  logic signed [IN_W+7:0] prod;
  logic signed [ACC_W-1:0] prod_ext, bias_ext, acc_r;
  logic signed [PW-1:0]   p, ps;
  logic signed [7:0]      q;

  assign last_beat = (beat_q == SW'(IN_LEN - 1));
  assign last_out  = (o_q == OW'(OUT_DIM - 1));

  // MAC cycle k consumes the weight addressed in cycle k-1, i.e. feature k-1.
  assign feat_idx = (k_q == '0) ? '0 : IW'(k_q - KW'(1));
  assign feat_sel = feat_q[feat_idx];
  assign prod     = feat_sel * w_data_i;
  assign prod_ext = {{(ACC_W - IN_W - 8){prod[IN_W+7]}}, prod};
  assign bias_ext = {{(ACC_W - 32){b_data_i[31]}}, b_data_i};

  // Requantisation of the finished accumulator.
  always_comb begin
    acc_r = (RELU && (acc_q < 0)) ? '0 : acc_q;
    p     = acc_r * QMul + Rnd;
    ps    = p >>> Q_SHIFT;
    if (ps > 127)       q = 8'sd127;
    else if (ps < -128) q = -8'sd128;
    else                q = ps[7:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StLoad;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (in_valid_i && last_beat) state_d = StBias;
      StBias:  state_d = StMac;
      StMac:   if (k_q == KW'(NIn)) state_d = StQuant;
      StQuant: state_d = StOut;
      StOut:   if (out_ready_i) state_d = last_out ? StLoad : StBias;
      default: state_d = StLoad;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready_o  = (state_q == StLoad);
    busy_o      = (state_q != StLoad);
    w_addr_o    = w_addr_q;
    b_addr_o    = BA_W'(o_q);
    out_valid_o = out_valid_q;
    out_data_o  = out_data_q;
    out_last_o  = out_last_q;
  end

  // Datapath and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q      <= '0;
      o_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      w_addr_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: if (in_valid_i) beat_q <= last_beat ? '0 : beat_q + SW'(1);
        StBias: k_q <= '0;
        StMac: begin
          k_q   <= k_q + KW'(1);
          acc_q <= (k_q == '0) ? bias_ext : acc_q + prod_ext;
          // Stop advancing after the last weight so stalls issue no new reads.
          if (k_q < KW'(NIn - 1)) w_addr_q <= w_addr_q + WA_W'(1);
        end
        StQuant: begin
          out_data_q  <= {{24{q[7]}}, q};
          out_valid_q <= 1'b1;
          out_last_q  <= last_out;
        end
        StOut: if (out_ready_i) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          if (last_out) begin
            o_q      <= '0;
            w_addr_q <= '0;
          end else begin
            o_q      <= o_q + OW'(1);
            // Last address used was o*N_IN+N_IN-1, so +1 is the next row base.
            w_addr_q <= w_addr_q + WA_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Feature buffer: no reset needed, every entry is rewritten each frame.
  always_ff @(posedge clk) begin
    if (state_q == StLoad && in_valid_i) begin
      for (int unsigned c = 0; c < IN_CH; c++) begin
        feat_q[IW'(c * IN_LEN + 32'(beat_q))] <= in_data_i[c*IN_W +: IN_W];
      end
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
module tb_fc_layer_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Small configuration: three DUTs in lock-step, differing only in RELU/Q_SHIFT.
  logic        in_valid = 1'b0;
  logic [63:0] in_data  = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_last_a, busy_a;
  logic        in_ready_b, out_valid_b, out_last_b, busy_b;
  logic        in_ready_d, out_valid_d, out_last_d, busy_d;
  logic [12:0] w_addr_a, w_addr_b, w_addr_d;
  logic [4:0]  b_addr_a, b_addr_b, b_addr_d;
  logic signed [7:0]  wd_a, wd_b, wd_d;
  logic signed [31:0] bd_a, bd_b, bd_d;
  logic [31:0] out_data_a, out_data_b, out_data_d;

  logic signed [7:0]  wrom [8];
  logic signed [31:0] brom [2];
  int feat [4];

  always @(posedge clk) begin
    wd_a <= wrom[w_addr_a[2:0]];
    wd_b <= wrom[w_addr_b[2:0]];
    wd_d <= wrom[w_addr_d[2:0]];
    bd_a <= brom[b_addr_a[0]];
    bd_b <= brom[b_addr_b[0]];
    bd_d <= brom[b_addr_d[0]];
  end

  fc_layer_seq #(.IN_CH(2), .IN_LEN(2), .OUT_DIM(2), .Q_MULT(1), .Q_SHIFT(0), .RELU(1'b1))
  u_dut_a (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_a), .in_data_i(in_data),
    .w_addr_o(w_addr_a), .w_data_i(wd_a), .b_addr_o(b_addr_a), .b_data_i(bd_a),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a),
    .out_last_o(out_last_a), .busy_o(busy_a)
  );

  fc_layer_seq #(.IN_CH(2), .IN_LEN(2), .OUT_DIM(2), .Q_MULT(1), .Q_SHIFT(0), .RELU(1'b0))
  u_dut_b (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_b), .in_data_i(in_data),
    .w_addr_o(w_addr_b), .w_data_i(wd_b), .b_addr_o(b_addr_b), .b_data_i(bd_b),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b),
    .out_last_o(out_last_b), .busy_o(busy_b)
  );

  fc_layer_seq #(.IN_CH(2), .IN_LEN(2), .OUT_DIM(2), .Q_MULT(1), .Q_SHIFT(2), .RELU(1'b0))
  u_dut_d (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_d), .in_data_i(in_data),
    .w_addr_o(w_addr_d), .w_data_i(wd_d), .b_addr_o(b_addr_d), .b_data_i(bd_d),
    .out_valid_o(out_valid_d), .out_ready_i(out_ready), .out_data_o(out_data_d),
    .out_last_o(out_last_d), .busy_o(busy_d)
  );

  // Default-size configuration with constant weight and zero bias.
  logic         in_valid_c = 1'b0;
  logic [511:0] in_data_c  = '0;
  logic         out_ready_c = 1'b0;
  logic signed [7:0] wc = 8'sd0;
  logic         in_ready_c, out_valid_c, out_last_c, busy_c;
  logic [12:0]  w_addr_c;
  logic [4:0]   b_addr_c;
  logic [31:0]  out_data_c;

  fc_layer_seq #(.Q_MULT(65536), .Q_SHIFT(16), .RELU(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_c), .in_ready_o(in_ready_c),
    .in_data_i(in_data_c), .w_addr_o(w_addr_c), .w_data_i(wc), .b_addr_o(b_addr_c),
    .b_data_i(32'sd0), .out_valid_o(out_valid_c), .out_ready_i(out_ready_c),
    .out_data_o(out_data_c), .out_last_o(out_last_c), .busy_o(busy_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] requant(input longint acc, input bit relu, input longint qm,
                                          input int qs);
    longint p;
    if (relu && acc < 0) acc = 0;
    p = acc * qm;
    if (qs > 0) p = p + (longint'(1) <<< (qs - 1));
    p = p >>> qs;
    if (p > 127) p = 127;
    else if (p < -128) p = -128;
    return 32'(p);
  endfunction

  function automatic longint dot(input int o);
    longint a = longint'(brom[o]);
    for (int i = 0; i < 4; i++) a += longint'(feat[i]) * longint'(wrom[o*4+i]);
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats();
    for (int s = 0; s < 2; s++) begin
      in_valid = 1'b1;
      in_data  = {32'(feat[2+s]), 32'(feat[s])};
      chk("in_ready_load", 64'(in_ready_a), 64'(1));
      step();
    end
    in_valid = 1'b0;
    chk("in_ready_drop", 64'(in_ready_a), 64'(0));
    chk("busy_high", 64'(busy_a), 64'(1));
  endtask

  // Collect both outputs; lat0 counts cycles already spent since the last beat.
  task automatic collect(input int lat0, input int stall);
    int lat = lat0;
    for (int o = 0; o < 2; o++) begin
      while (!out_valid_a && lat < 50) begin
        step();
        lat++;
      end
      chk("latency", 64'(lat), 64'(7));
      chk("data_relu", 64'(out_data_a), 64'(requant(dot(o), 1'b1, 1, 0)));
      chk("data_norelu", 64'(out_data_b), 64'(requant(dot(o), 1'b0, 1, 0)));
      chk("data_round", 64'(out_data_d), 64'(requant(dot(o), 1'b0, 1, 2)));
      chk("out_last", 64'(out_last_a), 64'(o == 1));
      chk("valid_lockstep", 64'({out_valid_b, out_valid_d}), 64'(3));
      if (o == 0) begin
        for (int c = 0; c < stall; c++) begin
          step();
          chk("stall_valid", 64'(out_valid_a), 64'(1));
          chk("stall_data", 64'(out_data_a), 64'(requant(dot(0), 1'b1, 1, 0)));
          chk("stall_last", 64'(out_last_a), 64'(0));
          chk("stall_waddr", 64'(w_addr_a), 64'(3));
        end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      lat = 0;
      chk("valid_drop", 64'(out_valid_a), 64'(0));
    end
    chk("in_ready_back", 64'(in_ready_a), 64'(1));
  endtask

  task automatic run_frame(input int stall, input int pulses);
    send_beats();
    for (int p = 0; p < pulses; p++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      step();
      chk("in_ready_busy", 64'(in_ready_a), 64'(0));
    end
    in_valid = 1'b0;
    collect(pulses, stall);
  endtask

  task automatic load_scenario1();
    feat = '{1, 2, 3, 4};
    wrom = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, -8'sd1, 8'sd0, 8'sd0, 8'sd0};
    brom = '{32'sd0, 32'sd0};
  endtask

  task automatic rand_frame(input int fr, input int wr, input int br);
    for (int i = 0; i < 4; i++) feat[i] = int'($urandom_range(0, 2 * fr)) - fr;
    for (int i = 0; i < 8; i++) wrom[i] = 8'(int'($urandom_range(0, 2 * wr)) - wr);
    for (int i = 0; i < 2; i++) brom[i] = int'($urandom_range(0, 2 * br)) - br;
  endtask

  task automatic run_big(input logic signed [7:0] w);
    int lat = 0;
    wc = w;
    for (int s = 0; s < 16; s++) begin
      in_valid_c = 1'b1;
      in_data_c  = {16{32'd100}};
      step();
    end
    in_valid_c = 1'b0;
    for (int o = 0; o < 32; o++) begin
      while (!out_valid_c && lat < 400) begin
        step();
        lat++;
      end
      chk("big_latency", 64'(lat), 64'(259));
      chk("big_data", 64'(out_data_c),
          64'(requant(longint'(256 * 100) * longint'(w), 1'b0, 65536, 16)));
      chk("big_last", 64'(out_last_c), 64'(o == 31));
      out_ready_c = 1'b1;
      step();
      out_ready_c = 1'b0;
      lat = 0;
    end
  endtask

  initial begin
    load_scenario1();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready_a), 64'(1));
    chk("rst_out_valid", 64'(out_valid_a), 64'(0));
    chk("rst_busy", 64'(busy_a), 64'(0));
    chk("rst_out_data", 64'(out_data_a), 64'(0));
    chk("rst_out_last", 64'(out_last_a), 64'(0));
    chk("rst_addr", 64'({w_addr_a, b_addr_a}), 64'(0));
    rst = 1'b0;
    step();

    // Directed frame: 10 then 0 (ReLU) / -1 (no ReLU).
    send_beats();
    for (int l = 0; l < 7; l++) begin
      chk("s1_not_yet", 64'(out_valid_a), 64'(0));
      step();
    end
    chk("s1_out0", 64'(out_data_a), 64'(10));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (7) step();
    chk("s1_out1_relu", 64'(out_data_a), 64'(0));
    chk("s2_out1_norelu", 64'(out_data_b), 64'hFFFF_FFFF);
    chk("s1_out1_last", 64'(out_last_a), 64'(1));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Rounding with Q_SHIFT=2: 6 -> 2, -6 -> -1, then 5 -> 1.
    feat = '{0, 0, 0, 0};
    brom = '{32'sd6, -32'sd6};
    send_beats();
    repeat (7) step();
    chk("round_pos6", 64'(out_data_d), 64'(2));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (7) step();
    chk("round_neg6", 64'(out_data_d), 64'hFFFF_FFFF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    brom = '{32'sd5, 32'sd0};
    send_beats();
    repeat (7) step();
    chk("round_pos5", 64'(out_data_d), 64'(1));
    collect(7, 0);

    // Backpressure on output 0 plus ignored beats during MAC.
    rand_frame(3, 20, 40);
    run_frame(10, 5);

    // Reset in the middle of MAC, then a clean frame.
    rand_frame(50, 127, 500);
    send_beats();
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid_a), 64'(0));
    chk("midrst_busy", 64'(busy_a), 64'(0));
    chk("midrst_in_ready", 64'(in_ready_a), 64'(1));
    #2;
    rst = 1'b0;
    step();
    load_scenario1();
    run_frame(0, 0);

    // Randomised frames, alternating small and saturating magnitudes.
    for (int f = 0; f < 8; f++) begin
      if (f % 2 == 0) rand_frame(3, 20, 40);
      else rand_frame(2000, 127, 100000);
      run_frame(f % 3, f % 4);
    end

    // Default-size layer: saturation high and low.
    run_big(8'sd127);
    run_big(-8'sd127);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
